uart_tx_fifo_param: RTL
=======================

Name: uart_tx_fifo_param

Overview:
Parametrised successor to the single-word RS-232 transmitter. Adds a small transmit FIFO, runtime-selectable data length, one or two stop bits, and an optional parity bit, and supports back-to-back frames. Bit timing comes from an external baud-tick strobe shared with the receiver side. Sits between the processor's memory-mapped UART register and the Tx pin.

Parameters:
DATA_W, 8, maximum data bits per frame; width of TxData.
FIFO_DEPTH, 4, transmit FIFO entries; must be a power of 2 and at least 2.
OVERSAMPLE, 16, Tick pulses per bit period.

Ports:
Clk  input  1  system clock; all logic on the rising edge.
Rst  input  1  synchronous, active-high reset.
TxEn  input  1  write strobe; pushes TxData into the FIFO when TxReady=1.
TxData  input  DATA_W  word to transmit, sent LSB first.
TxReady  output  1  FIFO not full.
Tick  input  1  one-cycle baud/oversample enable strobe.
NBits  input  4  data bits per frame, 1..DATA_W; 0 or greater than DATA_W means DATA_W.
StopBits  input  1  0 = one stop bit, 1 = two stop bits.
ParityMode  input  2  00 none, 01 odd, 10 even, 11 none.
Tx  output  1  serial line; idles high.
TxBusy  output  1  high while a frame is on the line.
TxDone  output  1  one-Clk pulse after the final stop bit completes.
FifoCount  output  $clog2(FIFO_DEPTH)+1  number of entries held in the FIFO.

Behaviour:
- Reset values: Tx=1, TxBusy=0, TxDone=0, FifoCount=0, TxReady=1. State is IDLE and the tick/bit counters are 0.
- Reset takes priority over every other input. Reset mid-frame: Tx=1 on the next cycle, FIFO flushed, no TxDone.
- FIFO write: TxEn=1 and not full pushes TxData at the edge.
  - TxEn while full: word dropped; no other effect.
  - Acceptance depends only on the full flag before that edge. A push and a pop in the same cycle are both legal.
- FIFO read: the FSM pops only on a transition into START.
- Registered outputs: Tx, TxDone, TxBusy.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE, FifoCount>0 at edge: pop the head word; latch NBits (clamped), StopBits and ParityMode; go to START with Tx=0, TxBusy=1. Config changes mid-frame have no effect.
  - START: after OVERSAMPLE Ticks, go to DATA with Tx = data bit 0.
  - DATA: each bit is held for OVERSAMPLE Ticks. After bit NBits-1, go to PARITY if parity is active, else to STOP.
  - PARITY: Tx = parity bit for OVERSAMPLE Ticks. Odd parity makes the count of ones over data plus parity odd; even parity makes it even. Parity is computed over the NBits data bits only. Then go to STOP.
  - STOP: Tx=1 for OVERSAMPLE ticks times (1 + StopBits). At completion TxDone pulses for one cycle, then:
    - FIFO non-empty: go directly to START, popping the next word. Tx goes 1→0 on that edge, so there is no idle gap and TxBusy stays 1.
    - FIFO empty: go to IDLE, TxBusy=0.
- Tick counter: increments only on cycles with Tick=1. It counts 0..OVERSAMPLE-1; the state or bit advances at the edge where the count reaches OVERSAMPLE-1 with Tick=1, and the counter then wraps to 0. The counter is cleared on entry to START.
- Latency: TxEn at edge N into an empty FIFO with the FSM idle → FifoCount=1 after N → Tx low after edge N+1.
- Tick held at 0: the FSM stalls in its current state and Tx holds. FIFO pushes still work.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: the PARITY state and parity generator are built, and ParityMode behaves as above.
- Undefined: the PARITY state is not synthesised. The ParityMode port remains present but is ignored, and every frame is treated as ParityMode=00.

Test Plan:
Bench setup for all scenarios: OVERSAMPLE=16, Tick=1 every cycle unless stated.
1. Reset, then TxEn one cycle with TxData=0x05, NBits=8, StopBits=0, ParityMode=00 → Tx low 2 cycles after TxEn. Line bits are 0,1,0,1,0,0,0,0,0,1, each held 16 cycles. TxDone pulses once 160 cycles after Tx fell; TxBusy then returns to 0.
2. UART_TX_PARITY_EN defined, TxData=0x05, NBits=8:
   - ParityMode=10 → parity bit 0.
   - ParityMode=01 → parity bit 1.
   - Frame length 176 cycles in both cases.
   - Rebuild without the macro and ParityMode=10 → 160-cycle frame, no parity bit.
3. NBits=5, StopBits=1, TxData=0xFF → data bits 1,1,1,1,1, then stop high for 32 cycles. Frame 7×16 + 16 = 128 cycles. NBits=0 gives an 8-bit frame.
4. FIFO_DEPTH=4, push 6 words (0x11..0x16) on consecutive cycles while idle. One is popped immediately, so 5 are accepted; TxReady=0 at the 6th push and 0x16 is dropped. Frames appear on Tx in order 0x11..0x15 with no idle gap. TxDone pulses 5 times; FifoCount reaches 0.
5. Tick asserted one cycle in four → each bit lasts 64 Clk cycles. Tick held 0 mid-DATA → Tx holds its value and resumes timing when Tick returns.
6. Rst=1 during bit 3 of a frame with 2 words queued → next cycle Tx=1, TxBusy=0, FifoCount=0, TxReady=1, and no TxDone.

Source files
------------

// File: rtl/uart_tx_fifo_param.sv
// Buffered RS-232 transmitter: FIFO, runtime data length, 1/2 stop bits, baud-tick timed.
// Optional parity generator and PARITY state are built when UART_TX_PARITY_EN is defined.
module uart_tx_fifo_param #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic                          TxEn,
  input  logic [DATA_W-1:0]             TxData,
  output logic                          TxReady,
  input  logic                          Tick,
  input  logic [3:0]                    NBits,
  input  logic                          StopBits,
  input  logic [1:0]                    ParityMode,
  output logic                          Tx,
  output logic                          TxBusy,
  output logic                          TxDone,
  output logic [$clog2(FIFO_DEPTH):0]   FifoCount
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
`endif

  // Transmit FIFO
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt, fifo_cnt_n;
  logic              fifo_full, push, pop, ready_q;
  logic [DATA_W-1:0] head;

  assign fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign push       = TxEn & ~fifo_full;
  assign fifo_cnt_n = fifo_cnt + CNT_W'(push) - CNT_W'(pop);
  assign head       = mem[rd_ptr];

  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= TxData;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      ready_q  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_cnt <= fifo_cnt_n;
      ready_q  <= (fifo_cnt_n != CNT_W'(FIFO_DEPTH));
    end
  end

  // Frame sequencer state
  logic [2:0]        state_q, state_n;
  logic [TICK_W-1:0] tick_q, tick_n;
  logic [BIT_W-1:0]  bit_q, bit_n, last_q, last_n, last_cfg;
  logic [DATA_W-1:0] shift_q, shift_n;
  logic              stop2_q, stop2_n;
  logic              tx_q, tx_n, busy_q, busy_n, done_q, done_n;
  logic              tick_end, load;
`ifdef UART_TX_PARITY_EN
  logic [1:0]        mode_q, mode_n;
  logic              par_q, par_n, par_on;
  assign par_on = (mode_q == 2'b01) || (mode_q == 2'b10);
`else
  logic              unused_parity_mode;
  assign unused_parity_mode = ^ParityMode;
`endif

  assign tick_end = Tick && (tick_q == TICK_W'(OVERSAMPLE - 1));

  // Out-of-range lengths fall back to the full data width
  always_comb begin
    if ((NBits == 4'd0) || (32'(NBits) > DATA_W)) last_cfg = BIT_W'(DATA_W - 1);
    else                                          last_cfg = BIT_W'(NBits - 4'd1);
  end

  always_comb begin
    state_n = state_q;
    tick_n  = tick_q;
    bit_n   = bit_q;
    last_n  = last_q;
    shift_n = shift_q;
    stop2_n = stop2_q;
    tx_n    = tx_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    load    = 1'b0;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    mode_n  = mode_q;
    par_n   = par_q;
`endif

    if ((state_q != S_IDLE) && Tick) tick_n = tick_end ? '0 : tick_q + TICK_W'(1);

    case (state_q)
      S_IDLE: load = (fifo_cnt != '0);
      S_START: begin
        if (tick_end) begin
          state_n = S_DATA;
          bit_n   = '0;
          tx_n    = shift_q[0];
        end
      end
      S_DATA: begin
        if (tick_end) begin
`ifdef UART_TX_PARITY_EN
          par_n = par_q ^ shift_q[0];
`endif
          if (bit_q == last_q) begin
            bit_n = '0;
`ifdef UART_TX_PARITY_EN
            if (par_on) begin
              state_n = S_PARITY;
              tx_n    = (mode_q == 2'b01) ? ~par_n : par_n;
            end else
`endif
            begin
              state_n = S_STOP;
              tx_n    = 1'b1;
            end
          end else begin
            bit_n   = bit_q + BIT_W'(1);
            shift_n = shift_q >> 1;
            tx_n    = shift_n[0];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (tick_end) begin
          state_n = S_STOP;
          bit_n   = '0;
          tx_n    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (tick_end) begin
          if (stop2_q && (bit_q == '0)) begin
            bit_n = BIT_W'(1);
          end else begin
            done_n = 1'b1;
            if (fifo_cnt != '0) begin
              load = 1'b1;
            end else begin
              state_n = S_IDLE;
              tx_n    = 1'b1;
              busy_n  = 1'b0;
            end
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase

    // Pop the next word and snapshot its frame configuration
    if (load) begin
      pop     = 1'b1;
      state_n = S_START;
      tick_n  = '0;
      bit_n   = '0;
      shift_n = head;
      last_n  = last_cfg;
      stop2_n = StopBits;
      tx_n    = 1'b0;
      busy_n  = 1'b1;
`ifdef UART_TX_PARITY_EN
      mode_n  = ParityMode;
      par_n   = 1'b0;
`endif
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      last_q  <= '0;
      shift_q <= '0;
      stop2_q <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      mode_q  <= 2'b00;
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      tick_q  <= tick_n;
      bit_q   <= bit_n;
      last_q  <= last_n;
      shift_q <= shift_n;
      stop2_q <= stop2_n;
      tx_q    <= tx_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
`ifdef UART_TX_PARITY_EN
      mode_q  <= mode_n;
      par_q   <= par_n;
`endif
    end
  end

  assign Tx        = tx_q;
  assign TxBusy    = busy_q;
  assign TxDone    = done_q;
  assign TxReady   = ready_q;
  assign FifoCount = fifo_cnt;

endmodule
